// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types, constants and elaboration helpers for the bcd_seq converter
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // All-9 BCD pattern for the given number of digits, used as the saturated result
    function automatic logic [63:0] all_nines(input int digits);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < digits && i < 16; i++)
            v[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd9;
        return v;
    endfunction

    // True when a W-bit value fits in DIGITS digits plus one guard digit
    function automatic bit fits(input int w, input int digits);
        longint p;
        p = 1;
        for (int i = 0; i <= digits; i++)
            p = p * 10;
        return (longint'(1) << w) <= p;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble correction cell, adds 3 to a BCD nibble that is 5 or more
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    // 4-bit add without carry out; inputs are always <=9 so the sum never wraps
    always_comb o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/bcd_seq.sv
// bcd_seq: iterative double-dabble binary-to-BCD converter with saturation and overflow flag
module bcd_seq
    import bcd_pkg::*;
#(
    parameter int W      = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   dec,
    output logic                  ovf
);

    localparam int BW = BCD_DIGIT_W * (DIGITS + 1);
    localparam int DW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W);
    localparam logic [DW-1:0] SAT  = DW'(all_nines(DIGITS));

    if (!fits(W, DIGITS)) begin : g_bad_width
        $error("bcd_seq: 2**W exceeds 10**(DIGITS+1)");
    end

    state_t         r_state;
    state_t         w_next;
    logic [BW-1:0]  r_bcd;
    logic [W-1:0]   r_bin;
    logic [CW-1:0]  r_cnt;
    logic [DW-1:0]  r_dec;
    logic           r_ovf;
    logic           r_done;
    logic [BW-1:0]  w_adj;
    logic           w_guard;

    for (genvar i = 0; i <= DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_nib (w_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign w_guard = |r_bcd[BW-1 -: BCD_DIGIT_W];

    // State register
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state: W shifts, one extra SHIFT cycle at count W, then a single DONE cycle
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && start)
            w_next = SHIFT;
        else if (r_state == SHIFT && r_cnt == LAST)
            w_next = DONE;
        else if (r_state == DONE)
            w_next = IDLE;
    end

    // Outputs derived from state
    always_comb busy = (r_state != IDLE);

    // Scratch shift register, iteration counter and held result
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_bcd  <= '0;
            r_bin  <= '0;
            r_cnt  <= '0;
            r_dec  <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_bin <= bin;
                r_bcd <= '0;
                r_cnt <= '0;
            end else if (r_state == SHIFT && r_cnt != LAST) begin
                {r_bcd, r_bin} <= {w_adj[BW-2:0], r_bin, 1'b0};
                r_cnt          <= r_cnt + CW'(1);
            end
            r_done <= (r_state == DONE);
            if (r_state == DONE) begin
                r_dec <= w_guard ? SAT : r_bcd[DW-1:0];
                r_ovf <= w_guard;
            end
        end
    end

    assign done = r_done;
    assign dec  = r_dec;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_bcd_seq.sv
// tb_bcd_seq: directed and sweep checks of the bcd_seq converter at default parameters
module tb_bcd_seq;

    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  bin = '0;
    logic        busy;
    logic        done;
    logic [11:0] dec;
    logic        ovf;

    int checks = 0;
    int failures = 0;

    bcd_seq #(.W(10), .DIGITS(3)) dut (
        .clk   (clk),
        .RSTn  (RSTn),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .dec   (dec),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ref_dec(input int v);
        if (v >= 1000) return 12'h999;
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Present start for one edge; returns #1 after the sampling edge
    task automatic launch(input logic [9:0] v);
        @(negedge clk);
        bin = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycles from now until done is seen (bounded)
    task automatic wait_done(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        RSTn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, dec, ovf} !== 15'd0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b dec=%h ovf=%b want all 0", busy, done, dec, ovf);
        end
        @(negedge clk);
        RSTn = 1'b1;
    endtask

    task automatic test_zero;
        int n;
        int nbusy;
        bit ok;
        launch(10'd0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_busy_after_accept got %b want 1", busy);
        end
        n = 0;
        nbusy = 0;
        ok = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                ok = 1'b1;
                break;
            end
            if (busy) nbusy++;
        end
        checks++;
        if (!ok || n != 12) begin
            failures++;
            $display("FAIL zero_latency got %0d (seen=%b) want 12", n, ok);
        end
        checks++;
        if (nbusy != 11 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_busy_cycles got %0d busy_at_done=%b want 11 and 0", nbusy, busy);
        end
        checks++;
        if (dec !== 12'h000 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL zero_result got dec=%h ovf=%b want 000 0", dec, ovf);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_width got done=%b want 0", done);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bit ok;
        launch(10'd255);
        wait_done(n, ok);
        checks++;
        if (!ok || n != 12 || dec !== 12'h255 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first got n=%0d dec=%h ovf=%b want 12 255 0", n, dec, ovf);
        end
        // Second start raised inside the done cycle
        bin = 10'd999;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (dec !== 12'h255) begin
            failures++;
            $display("FAIL b2b_hold got dec=%h want 255", dec);
        end
        wait_done(n, ok);
        checks++;
        if (!ok || n != 7 || dec !== 12'h999 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second got n=%0d dec=%h ovf=%b want 7 999 0", n, dec, ovf);
        end
    endtask

    task automatic test_overflow;
        int n;
        bit ok;
        launch(10'd1000);
        wait_done(n, ok);
        checks++;
        if (!ok || dec !== 12'h999 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_1000 got seen=%b dec=%h ovf=%b want 999 1", ok, dec, ovf);
        end
        launch(10'd1023);
        wait_done(n, ok);
        checks++;
        if (!ok || dec !== 12'h999 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_1023 got seen=%b dec=%h ovf=%b want 999 1", ok, dec, ovf);
        end
        launch(10'd9);
        wait_done(n, ok);
        checks++;
        if (!ok || dec !== 12'h009 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got seen=%b dec=%h ovf=%b want 009 0", ok, dec, ovf);
        end
    endtask

    task automatic test_busy_ignore;
        int ndone;
        launch(10'd512);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bin = 10'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                checks++;
                if (dec !== 12'h512 || ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_ignore_result got dec=%h ovf=%b want 512 0", dec, ovf);
                end
            end
        end
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL busy_ignore_count got %0d done pulses want 1", ndone);
        end
    endtask

    task automatic test_async_reset;
        int n;
        int ndone;
        bit ok;
        launch(10'd300);
        repeat (5) @(posedge clk);
        #3;
        RSTn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || dec !== 12'h000 || done !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got busy=%b dec=%h done=%b ovf=%b want 0 000 0 0", busy, dec, done, ovf);
        end
        @(negedge clk);
        RSTn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone != 0 || busy !== 1'b0 || dec !== 12'h000) begin
            failures++;
            $display("FAIL async_reset_quiet got done_pulses=%0d busy=%b dec=%h want 0 0 000", ndone, busy, dec);
        end
        launch(10'd42);
        wait_done(n, ok);
        checks++;
        if (!ok || n != 12 || dec !== 12'h042 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_after got n=%0d dec=%h ovf=%b want 12 042 0", n, dec, ovf);
        end
    endtask

    task automatic test_sweep;
        int n;
        bit ok;
        int bad;
        bad = 0;
        for (int v = 0; v < 1024; v++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            launch(10'(v));
            wait_done(n, ok);
            checks++;
            if (!ok || n != 12 || dec !== ref_dec(v) || ovf !== (v >= 1000)) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL sweep_%0d got n=%0d dec=%h ovf=%b want 12 %h %b", v, n, dec, ovf, ref_dec(v), v >= 1000);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL sweep_width_%0d done still high", v);
            end
        end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_back_to_back;
        test_overflow;
        test_busy_ignore;
        test_async_reset;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
